// File: rtl/xnor_match_pipe.sv
// Two-stage valid/ready bitwise logic unit with per-transaction bit-equality
// count, all-equal flag and a saturating tally of delivered all-equal results.
module xnor_match_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned MW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic [MW-1:0]    match_cnt,
    output logic             all_equal,
    output logic [CNT_W-1:0] eq_total,
    input  logic             eq_clear
);

    typedef enum logic [2:0] {
        OpAnd  = 3'd0,
        OpOr   = 3'd1,
        OpXor  = 3'd2,
        OpXnor = 3'd3,
        OpNand = 3'd4,
        OpNor  = 3'd5,
        OpPass = 3'd6,
        OpNot  = 3'd7
    } op_e;

    logic             s1_v_q;
    logic [WIDTH-1:0] s1_f_q;
    logic [WIDTH-1:0] s1_eq_q;

    logic             s2_v_q;
    logic             s2_v_d;
    logic [WIDTH-1:0] s2_f_q;
    logic [MW-1:0]    s2_cnt_q;
    logic             s2_all_q;

    logic [CNT_W-1:0] eq_total_q;
    logic [CNT_W-1:0] eq_total_d;

    logic             s1_load;
    logic             s2_load;
    logic             out_xfer;
    logic [WIDTH-1:0] f_d;
    logic [MW-1:0]    cnt_d;

    // Ready chain is purely combinational: a full pipe frees S1 in the same
    // cycle that downstream takes the S2 result.
    always_comb begin
        s2_load  = s1_v_q && (!s2_v_q || out_ready);
        s1_load  = !s1_v_q || s2_load;
        out_xfer = s2_v_q && out_ready;
        in_ready = s1_load;
    end

    always_comb begin
        f_d = '0;
        unique case (op_e'(op))
            OpAnd:  f_d = a & b;
            OpOr:   f_d = a | b;
            OpXor:  f_d = a ^ b;
            OpXnor: f_d = ~(a ^ b);
            OpNand: f_d = ~(a & b);
            OpNor:  f_d = ~(a | b);
            OpPass: f_d = a;
            OpNot:  f_d = ~a;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d = cnt_d + MW'(s1_eq_q[i]);
        end
    end

    always_comb begin
        if (s2_load) begin
            s2_v_d = 1'b1;
        end else if (out_xfer) begin
            s2_v_d = 1'b0;
        end else begin
            s2_v_d = s2_v_q;
        end
    end

    // Clear wins over a same-cycle increment; the counter never wraps.
    always_comb begin
        eq_total_d = eq_total_q;
        if (out_xfer && s2_all_q && (eq_total_q != {CNT_W{1'b1}})) begin
            eq_total_d = eq_total_q + 1'b1;
        end
        if (eq_clear) begin
            eq_total_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q  <= 1'b0;
            s1_f_q  <= '0;
            s1_eq_q <= '0;
        end else if (s1_load) begin
            s1_v_q <= in_valid;
            if (in_valid) begin
                s1_f_q  <= f_d;
                s1_eq_q <= ~(a ^ b);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v_q   <= 1'b0;
            s2_f_q   <= '0;
            s2_cnt_q <= '0;
            s2_all_q <= 1'b0;
        end else begin
            s2_v_q <= s2_v_d;
            if (s2_load) begin
                s2_f_q   <= s1_f_q;
                s2_cnt_q <= cnt_d;
                s2_all_q <= &s1_eq_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq_total_q <= '0;
        end else begin
            eq_total_q <= eq_total_d;
        end
    end

    assign out_valid = s2_v_q;
    assign f         = s2_f_q;
    assign match_cnt = s2_cnt_q;
    assign all_equal = s2_all_q;
    assign eq_total  = eq_total_q;

endmodule

// File: tb/tb_xnor_match_pipe.sv
// Bench for xnor_match_pipe: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_xnor_match_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] op = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] f;
    logic [3:0] match_cnt;
    logic       all_equal;
    logic [1:0] eq_total;
    logic       eq_clear = 1'b0;

    xnor_match_pipe #(.WIDTH(8), .CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .match_cnt (match_cnt),
        .all_equal (all_equal),
        .eq_total  (eq_total),
        .eq_clear  (eq_clear)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what each transaction must produce, straight from the op table.
    function automatic logic [7:0] ref_f(input logic [2:0] o, input logic [7:0] x,
                                         input logic [7:0] y);
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~(x ^ y);
            3'd4: return ~(x & y);
            3'd5: return ~(x | y);
            3'd6: return x;
            default: return ~x;
        endcase
    endfunction

    typedef struct {
        logic [7:0] f;
        int         mc;
        bit         ae;
        int         t;
    } exp_t;

    exp_t       q[$];
    logic [7:0] dlog[$];
    int         mlog[$];
    bit         alog[$];
    int         latlog[$];
    int         cyc = 0;
    int         m_eq = 0;
    int         total_acc = 0;
    bit         last_acc = 0;

    // Compare process: outputs are stable between the driving edge (+1) and
    // the next posedge, so everything is judged at the falling edge.
    always @(negedge clk) begin
        int  n;
        bit  ov_exp;
        bit  oxfer;
        int  nxt;
        cyc++;
        if (rst) begin
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_f", f, 0);
            chk("rst_match_cnt", match_cnt, 0);
            chk("rst_all_equal", all_equal, 0);
            chk("rst_eq_total", eq_total, 0);
            q.delete();
            m_eq = 0;
            last_acc = 0;
        end else begin
            n = q.size();
            chk("in_ready", in_ready, (n < 2) || out_ready);
            ov_exp = (n > 0) && (q[0].t <= cyc - 2);
            chk("out_valid", out_valid, ov_exp);
            if (out_valid && n > 0) begin
                chk("f", f, q[0].f);
                chk("match_cnt", match_cnt, q[0].mc);
                chk("all_equal", all_equal, q[0].ae);
            end
            chk("eq_total", eq_total, m_eq);
            oxfer = out_valid && out_ready && (n > 0);
            nxt = m_eq;
            if (oxfer) begin
                dlog.push_back(q[0].f);
                mlog.push_back(q[0].mc);
                alog.push_back(q[0].ae);
                latlog.push_back(cyc - q[0].t);
                if (q[0].ae && m_eq != 3) nxt = m_eq + 1;
                void'(q.pop_front());
            end
            if (eq_clear) nxt = 0;
            m_eq = nxt;
            last_acc = in_valid && in_ready;
            if (last_acc) begin
                q.push_back('{ref_f(op, a, b), $countones(~(a ^ b)), (a == b), cyc});
                total_acc++;
            end
        end
    end

    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] top);
        bit acc;
        int k;
        in_valid = 1'b1;
        a = ta;
        b = tb;
        op = top;
        k = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            k++;
        end while (!acc && k < 50);
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] op_exp [8] = '{8'h0C, 8'h3F, 8'h33, 8'hCC, 8'hF3, 8'hC0, 8'h0F, 8'hF0};
    logic [7:0] bp_exp [5] = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFB};
    int         sat_exp [5] = '{1, 2, 3, 3, 3};

    initial begin
        int base;
        idle(3);
        rst = 1'b0;
        idle(2);

        // All eight ops on 0F/3C, full throughput.
        base = dlog.size();
        for (int i = 0; i < 8; i++) send(8'h0F, 8'h3C, 3'(i));
        idle(4);
        chk("ops_count", dlog.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < dlog.size()) begin
                chk($sformatf("op%0d_f", i), dlog[base+i], op_exp[i]);
                chk($sformatf("op%0d_mc", i), mlog[base+i], 4);
                chk($sformatf("op%0d_ae", i), alog[base+i], 0);
                chk($sformatf("op%0d_lat", i), latlog[base+i], 2);
            end
        end

        // Equal operands.
        base = dlog.size();
        send(8'hA5, 8'hA5, 3'd3);
        idle(4);
        chk("eq_count", dlog.size() - base, 1);
        if (dlog.size() > base) begin
            chk("eq_f", dlog[base], 8'hFF);
            chk("eq_mc", mlog[base], 8);
            chk("eq_ae", alog[base], 1);
        end
        chk("eq_total_1", eq_total, 1);

        // Backpressure: 5 back-to-back items, downstream stalled 4 cycles.
        base = dlog.size();
        fork
            begin
                for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 8'h10, 3'd3);
            end
            begin
                int acc0;
                acc0 = total_acc;
                out_ready = 1'b0;
                @(negedge clk);
                @(negedge clk);
                @(negedge clk);
                #1;
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_accepted", total_acc - acc0, 2);
                @(posedge clk);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(6);
        chk("bp_count", dlog.size() - base, 5);
        for (int i = 0; i < 5; i++) begin
            if (base + i < dlog.size()) chk($sformatf("bp%0d_f", i), dlog[base+i], bp_exp[i]);
        end

        // Saturation at 3 with CNT_W=2.
        eq_clear = 1'b1;
        idle(1);
        eq_clear = 1'b0;
        chk("clr_eq_total", eq_total, 0);
        for (int i = 0; i < 5; i++) begin
            send(8'h5A, 8'h5A, 3'd3);
            idle(3);
            chk($sformatf("sat%0d", i), eq_total, sat_exp[i]);
        end

        // Clear concurrent with an incrementing transfer.
        base = dlog.size();
        send(8'h77, 8'h77, 3'd0);
        idle(1);
        eq_clear = 1'b1;
        idle(1);
        eq_clear = 1'b0;
        chk("clr_prio_xfer", dlog.size() - base, 1);
        chk("clr_prio_total", eq_total, 0);

        // Random traffic with legal producer hold behaviour.
        for (int i = 0; i < 3000; i++) begin
            if (!(in_valid && !last_acc)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a = 8'($urandom);
                b = ($urandom_range(0, 1) == 1) ? a : 8'($urandom);
                op = 3'($urandom_range(0, 7));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            eq_clear = ($urandom_range(0, 63) == 0);
            idle(1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        eq_clear = 1'b0;
        idle(5);
        chk("drain_empty", q.size(), 0);

        // Reset mid-stream, asynchronously.
        in_valid = 1'b1;
        a = 8'hC3;
        b = 8'hC3;
        op = 3'd3;
        repeat (4) @(posedge clk);
        #2;
        chk("pre_rst_ov", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_f", f, 0);
        chk("arst_match_cnt", match_cnt, 0);
        chk("arst_eq_total", eq_total, 0);
        chk("arst_in_ready", in_ready, 1);
        in_valid = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(3);
        chk("post_rst_ov", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
